multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multi-cycle successor to the single-cycle RISC-V control decoder. A Moore-style FSM sequences each instruction over 3–5 cycles so that one memory port and one ALU are shared between fetch, address and execute. It generalises the single-cycle decoder with parametrised instruction subsets (bne, jal, I-type ALU, memory-mapped I/O), a memory-ready handshake and a trap state for illegal opcodes. It sits between the instruction register and the multi-cycle datapath muxes and enables.

## Interface
- ENABLE_BNE, default 1: funct3=001 branches are decoded as bne; when 0 they are illegal.
- ENABLE_JAL, default 1: op 1101111 is decoded; when 0 it is illegal.
- ENABLE_IO, default 1: lw/sw with funct3=111 use the I/O bus; when 0 they are ordinary memory accesses.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- mem_ready  in  1  memory completes the current access this cycle.
- Zero  in  1  ALU zero flag, combinational from the datapath.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- MemWrite  out  1  data memory write.
- IRWrite  out  1  instruction register enable.
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1.
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=imm, 10=4.
- ImmSrc  out  2  immediate type: 00=I, 01=S, 10=B, 11=J.
- RegWrite  out  1  register file write.
- ALUControl  out  3  ALU operation code.
- InputSRC  out  1  writeback takes data from the INPUT bus.
- OutputSRC  out  1  latch rs2 onto the OUTPUT bus.
- IllegalInstr  out  1  sticky trap indicator.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, IOREAD, IOWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- **Outputs not listed for a state** are 0. Exception: ALUSrcA, ALUSrcB and ResultSrc default to 00.

State behaviour:
- **FETCH:**
  - Drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=add.
  - IRWrite and PCWrite are asserted only when mem_ready=1. The FSM then moves to DECODE; otherwise it stays in FETCH.
- **DECODE:** ALUSrcA=01, ALUSrcB=01, ALUOp=add (computes the branch/jump target). Next state by op:
  - 0000011 → IOREAD if ENABLE_IO and funct3=111, else MEMADR.
  - 0100011 → IOWRITE if ENABLE_IO and funct3=111, else MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BRANCH. If funct3 is not 000 (or 001 with ENABLE_BNE=1), go to TRAP instead.
  - 1101111 → JAL if ENABLE_JAL, else TRAP.
  - Any other op → TRAP.
- **MEMADR:** ALUSrcA=10, ALUSrcB=01, ALUOp=add. Next is MEMREAD for loads, MEMWRITE for stores.
- **MEMREAD:** AdrSrc=1. Stays until mem_ready, then MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1. Next is FETCH.
- **MEMWRITE:** AdrSrc=1, MemWrite=1, held until mem_ready. Next is FETCH.
- **IOREAD:** InputSRC=1, RegWrite=1. One cycle, then FETCH.
- **IOWRITE:** OutputSRC=1, MemWrite=0. One cycle, then FETCH.
- **EXECR / EXECI:** ALUSrcA=10; ALUSrcB=00 (EXECR) or 01 (EXECI); ALUOp=funct. Next is ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1. Next is FETCH.
- **BRANCH:**
  - Drives ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00.
  - PCWrite = Zero for beq, and !Zero for bne. This is Mealy on Zero.
  - Next is FETCH.
- **JAL:** ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1 (rd value is OldPC+4). Next is ALUWB.
- **TRAP:** IllegalInstr=1, all enables 0. The FSM remains in TRAP until reset.

ImmSrc is combinational from op: loads and 0010011 → 00; 0100011 → 01; 1100011 → 10; 1101111 → 11; otherwise 00.

ALUControl encoding:
- add=000, sub=001, and=010, or=011, slt=101, sra=110.
- In funct mode, funct3 selects the operation:
  - 000: sub if op[5]&funct7_5, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - 101: sra when funct7_5=1, otherwise add.
  - Other funct3 values: add.
- No X outputs in any state.

## Timing
- **Reset:**
  - With reset=1 at a rising edge, state becomes FETCH and IllegalInstr becomes 0.
  - While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and OutputSRC are forced to 0.
  - Reset takes priority over every transition, including a mid-instruction state or TRAP.
- **Latency with mem_ready tied to 1:**
  - lw: 5 cycles. sw: 4. R-type and I-type ALU: 4. beq/bne: 3. jal: 4. I/O lw and sw: 3.
- **Memory wait:** each cycle mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. All outputs are held stable while waiting.
- **Mealy paths:** the only combinational input-to-output paths are mem_ready→IRWrite/PCWrite in FETCH and Zero→PCWrite in BRANCH.

## Test plan
- **Reset:** assert reset for 2 cycles mid-MEMREAD → next state FETCH, all write enables 0 during reset, IllegalInstr=0.
- **lw with memory wait:** op=0000011, funct3=010, mem_ready low for 2 cycles in MEMREAD → 7 cycles total. RegWrite=1 with ResultSrc=01 for exactly one cycle.
- **R-type sub:** op=0110011, funct3=000, funct7_5=1 → ALUControl=001 in EXECR. Then RegWrite=1 in ALUWB. 4 cycles.
- **bne with ENABLE_BNE=1:**
  - funct3=001, Zero=0 in BRANCH → PCWrite=1.
  - Repeat with Zero=1 → PCWrite=0.
  - With ENABLE_BNE=0 → TRAP with IllegalInstr=1.
- **I/O:**
  - sw with funct3=111 → OutputSRC=1 for one cycle, MemWrite never 1.
  - lw with funct3=111 → InputSRC=1 and RegWrite=1 in the same cycle.
- **Illegal opcode:** op=1111111 → TRAP. The FSM stays there for 10 cycles with no enables asserted, and leaves to FETCH only on reset.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Moore-style control FSM for a multi-cycle RISC-V datapath. Each instruction
// is sequenced over 3-5 cycles so one memory port and one ALU can be shared
// between fetch, address generation and execute.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   mem_ready         memory completes the current access this cycle
//   Zero              ALU zero flag from the datapath
//   op/funct3/funct7_5  instruction register fields
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ImmSrc, RegWrite, ALUControl     datapath mux selects and enables
//   InputSRC, OutputSRC              memory-mapped I/O bus controls
//   IllegalInstr      sticky trap indicator (cleared only by reset)
//   debug_state       current FSM state encoding, for observation only
//
// Memory handshake: the FSM presents an access (FETCH, MEMREAD, MEMWRITE) and
// holds every output stable until mem_ready=1 is sampled on a rising edge;
// that edge completes the access and advances the FSM.
module multicycle_control_unit #(
    parameter bit ENABLE_BNE = 1'b1,
    parameter bit ENABLE_JAL = 1'b1,
    parameter bit ENABLE_IO  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_ready,
    input  logic       Zero,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       InputSRC,
    output logic       OutputSRC,
    output logic       IllegalInstr,
    output logic [3:0] debug_state
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, IOREAD, IOWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SRA = 3'b110;

    // Registered Moore outputs plus the qualifiers the Mealy terms need.
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       input_src;
        logic       output_src;
        logic       illegal;
        logic       jal_pc;     // unconditional PC write (JAL)
        logic       fetch;      // IRWrite/PCWrite gated by mem_ready
        logic       branch;     // PCWrite gated by Zero
        logic       bne;        // invert Zero for bne
    } moore_t;

    state_t state;
    state_t next_state;
    moore_t ctl_q;

    function automatic logic [2:0] funct_alu(logic [6:0] o, logic [2:0] f3, logic f75);
        case (f3)
            3'b000:  return (o[5] && f75) ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            3'b101:  return f75 ? ALU_SRA : ALU_ADD;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic moore_t moore_of(state_t s, logic [6:0] o, logic [2:0] f3, logic f75);
        moore_t m;
        m = '0;
        case (s)
            FETCH:    begin m.alu_src_b = 2'b10; m.result_src = 2'b10; m.fetch = 1'b1; end
            DECODE:   begin m.alu_src_a = 2'b01; m.alu_src_b = 2'b01; end
            MEMADR:   begin m.alu_src_a = 2'b10; m.alu_src_b = 2'b01; end
            MEMREAD:  m.adr_src = 1'b1;
            MEMWB:    begin m.result_src = 2'b01; m.reg_write = 1'b1; end
            MEMWRITE: begin m.adr_src = 1'b1; m.mem_write = 1'b1; end
            IOREAD:   begin m.input_src = 1'b1; m.reg_write = 1'b1; end
            IOWRITE:  m.output_src = 1'b1;
            EXECR:    begin m.alu_src_a = 2'b10; m.alu_control = funct_alu(o, f3, f75); end
            EXECI:    begin
                m.alu_src_a   = 2'b10;
                m.alu_src_b   = 2'b01;
                m.alu_control = funct_alu(o, f3, f75);
            end
            ALUWB:    m.reg_write = 1'b1;
            BRANCH:   begin
                m.alu_src_a   = 2'b10;
                m.alu_control = ALU_SUB;
                m.branch      = 1'b1;
                m.bne         = f3[0];
            end
            JAL:      begin m.alu_src_a = 2'b01; m.alu_src_b = 2'b10; m.jal_pc = 1'b1; end
            TRAP:     m.illegal = 1'b1;
            default:  m = '0;
        endcase
        return m;
    endfunction

    always_comb begin
        next_state = state;
        case (state)
            FETCH:    next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LOAD:   next_state = (ENABLE_IO && funct3 == 3'b111) ? IOREAD : MEMADR;
                    OP_STORE:  next_state = (ENABLE_IO && funct3 == 3'b111) ? IOWRITE : MEMADR;
                    OP_RTYPE:  next_state = EXECR;
                    OP_ITYPE:  next_state = EXECI;
                    OP_BRANCH: next_state = (funct3 == 3'b000 || (ENABLE_BNE && funct3 == 3'b001))
                                            ? BRANCH : TRAP;
                    OP_JAL:    next_state = ENABLE_JAL ? JAL : TRAP;
                    default:   next_state = TRAP;
                endcase
            end
            // op[5] separates stores (0100011) from loads (0000011).
            MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL: next_state = ALUWB;
            MEMWB, IOREAD, IOWRITE, ALUWB, BRANCH: next_state = FETCH;
            TRAP:     next_state = TRAP;
            default:  next_state = FETCH;
        endcase
    end

    // Outputs are registered from the state being entered, so each state's
    // Moore outputs are valid for the whole cycle it occupies.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            ctl_q <= moore_of(FETCH, op, funct3, funct7_5);
        end else begin
            state <= next_state;
            ctl_q <= moore_of(next_state, op, funct3, funct7_5);
        end
    end

    // Write enables are forced low while reset is held, whatever the state.
    assign PCWrite   = ~reset & (ctl_q.jal_pc | (ctl_q.fetch & mem_ready)
                                 | (ctl_q.branch & (Zero ^ ctl_q.bne)));
    assign IRWrite   = ~reset & ctl_q.fetch & mem_ready;
    assign MemWrite  = ~reset & ctl_q.mem_write;
    assign RegWrite  = ~reset & ctl_q.reg_write;
    assign OutputSRC = ~reset & ctl_q.output_src;

    assign AdrSrc       = ctl_q.adr_src;
    assign ResultSrc    = ctl_q.result_src;
    assign ALUSrcA      = ctl_q.alu_src_a;
    assign ALUSrcB      = ctl_q.alu_src_b;
    assign ALUControl   = ctl_q.alu_control;
    assign InputSRC     = ctl_q.input_src;
    assign IllegalInstr = ctl_q.illegal;
    assign debug_state  = state;

    always_comb begin
        case (op)
            OP_LOAD, OP_ITYPE: ImmSrc = 2'b00;
            OP_STORE:          ImmSrc = 2'b01;
            OP_BRANCH:         ImmSrc = 2'b10;
            OP_JAL:            ImmSrc = 2'b11;
            default:           ImmSrc = 2'b00;
        endcase
    end

endmodule
